mul_16_3: RTL and testbench



---
 rtl/div_16_3_pkg.sv | 17 +
 rtl/mul_16_3_if.sv | 38 +++
 rtl/mul_16_3_core.sv | 29 ++
 rtl/mul_16_3.sv | 80 ++++++++
 tb/tb_mul_16_3.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/div_16_3_pkg.sv
// rtl/div_16_3_pkg.sv - shared widths for the divide-by-3 / multiply-by-3 pair
package div_16_3_pkg;

   localparam int X_W     = 16;
   localparam int Q_W     = 15;
   localparam int R_W     = 2;
   localparam int DIVISOR = 3;

   // 3Q+R needs one bit beyond X_W so an overflow can be seen before wrapping
   localparam int SUM_W   = X_W + 1;

   typedef logic [Q_W:1]   quot_t;
   typedef logic [R_W:1]   rem_t;
   typedef logic [X_W:1]   dividend_t;
   typedef logic [SUM_W:1] sum_t;

endpackage

// File: rtl/mul_16_3_if.sv
// rtl/mul_16_3_if.sv - operand/result handshake bundle for mul_16_3
// ERR_out exists only when MUL_16_3_RANGE_CHECK_EN is defined.
interface mul_16_3_if;
   import div_16_3_pkg::*;

   quot_t     IN_Q;
   rem_t      IN_R;
   logic      IN_VALID;
   logic      IN_READY;
   dividend_t X_out;
   logic      OUT_VALID;
   logic      OUT_READY;

`ifdef MUL_16_3_RANGE_CHECK_EN
   logic      ERR_out;

   modport master (
      output IN_Q, IN_R, IN_VALID, OUT_READY,
      input  IN_READY, X_out, OUT_VALID, ERR_out
   );

   modport slave (
      input  IN_Q, IN_R, IN_VALID, OUT_READY,
      output IN_READY, X_out, OUT_VALID, ERR_out
   );
`else
   modport master (
      output IN_Q, IN_R, IN_VALID, OUT_READY,
      input  IN_READY, X_out, OUT_VALID
   );

   modport slave (
      input  IN_Q, IN_R, IN_VALID, OUT_READY,
      output IN_READY, X_out, OUT_VALID
   );
`endif

endinterface

// File: rtl/mul_16_3_core.sv
// rtl/mul_16_3_core.sv - combinational 3Q+R at full 17-bit width
// The err term is built only when MUL_16_3_RANGE_CHECK_EN is defined.
module mul_16_3_core
   import div_16_3_pkg::*;
(
   input  quot_t q,
   input  rem_t  r,
`ifdef MUL_16_3_RANGE_CHECK_EN
   output logic  err,
`endif
   output sum_t  sum
);

   sum_t q_ext;
   sum_t q_dbl;
   sum_t r_ext;

   assign q_ext = {2'b00, q};
   assign q_dbl = {1'b0, q, 1'b0};
   assign r_ext = {{(SUM_W - R_W){1'b0}}, r};

   assign sum = q_dbl + q_ext + r_ext;

`ifdef MUL_16_3_RANGE_CHECK_EN
   // R=3 is not a legal remainder; a carry out means X does not fit in X_W bits
   assign err = (r == rem_t'(DIVISOR)) || sum[SUM_W];
`endif

endmodule

// File: rtl/mul_16_3.sv
// rtl/mul_16_3.sv - two-stage valid/ready pipeline reconstructing X = 3Q + R
// ERR_out and the range check are present only with MUL_16_3_RANGE_CHECK_EN.
module mul_16_3
   import div_16_3_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   mul_16_3_if.slave  bus
);

   quot_t     s1_q;
   rem_t      s1_r;
   logic      s1_valid;
   dividend_t s2_x;
   logic      s2_valid;
   logic      s1_en;
   logic      s2_en;
   sum_t      sum;

   // A stage may load when it is empty or its contents leave this cycle
   assign s2_en = !s2_valid || bus.OUT_READY;
   assign s1_en = !s1_valid || s2_en;

   assign bus.IN_READY  = s1_en;
   assign bus.X_out     = s2_x;
   assign bus.OUT_VALID = s2_valid;

`ifdef MUL_16_3_RANGE_CHECK_EN
   logic core_err;
   logic s2_err;

   assign bus.ERR_out = s2_err;

   mul_16_3_core u_core (
      .q   (s1_q),
      .r   (s1_r),
      .err (core_err),
      .sum (sum)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_err <= 1'b0;
      end else if (s2_en) begin
         s2_err <= core_err;
      end
   end
`else
   logic unused_carry;

   assign unused_carry = sum[SUM_W];

   mul_16_3_core u_core (
      .q   (s1_q),
      .r   (s1_r),
      .sum (sum)
   );
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q     <= '0;
         s1_r     <= '0;
         s1_valid <= 1'b0;
         s2_x     <= '0;
         s2_valid <= 1'b0;
      end else begin
         if (s2_en) begin
            s2_x     <= sum[X_W:1];
            s2_valid <= s1_valid;
         end
         if (s1_en) begin
            s1_q     <= bus.IN_Q;
            s1_r     <= bus.IN_R;
            s1_valid <= bus.IN_VALID;
         end
      end
   end

endmodule

// File: tb/tb_mul_16_3.sv
// tb/tb_mul_16_3.sv - scoreboard bench for mul_16_3 (works with or without MUL_16_3_RANGE_CHECK_EN)
module tb_mul_16_3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   n_push = 0;
   int   n_pop = 0;
   logic [16:0] exp_q[$];
   logic        held_valid = 1'b0;
   logic [15:0] held_x = '0;

   mul_16_3_if bus();

   mul_16_3 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // {err, x} straight from the arithmetic definition of the block
   function automatic logic [16:0] model(input int q, input int r);
      int v;
      v = 3 * q + r;
      return {(r == 3) || (v > 65535), v[15:0]};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", nm, act, req);
      end
   endtask

   // Monitor: transfers are decided at the next rising edge, so look at the falling edge
   always @(negedge clk) begin
      logic [16:0] e;
      if (!rst_n) begin
         exp_q.delete();
         held_valid = 1'b0;
      end else begin
         if (held_valid) begin
            check("hold_valid", 32'(bus.OUT_VALID), 32'd1);
            check("hold_x", 32'(bus.X_out), 32'(held_x));
         end
         if (bus.OUT_VALID && bus.OUT_READY) begin
            n_pop++;
            if (exp_q.size() == 0) begin
               check("unexpected_out", 32'(bus.X_out), 32'hDEAD_BEEF);
            end else begin
               e = exp_q.pop_front();
               check("sb_x", 32'(bus.X_out), 32'(e[15:0]));
`ifdef MUL_16_3_RANGE_CHECK_EN
               check("sb_err", 32'(bus.ERR_out), 32'(e[16]));
`endif
            end
         end
         if (bus.IN_VALID && bus.IN_READY) begin
            n_push++;
            exp_q.push_back(model(int'(bus.IN_Q), int'(bus.IN_R)));
         end
         held_valid = bus.OUT_VALID && !bus.OUT_READY;
         held_x = bus.X_out;
      end
   end

   task automatic drain(input string nm);
      int n;
      bus.IN_VALID = 1'b0;
      bus.OUT_READY = 1'b1;
      n = 0;
      while ((exp_q.size() != 0 || bus.OUT_VALID) && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({nm, "_drain_timeout"}, 32'(n < 10), 32'd1);
   endtask

   // Operand presented, captured by S1 at the first edge, visible from S2 after the second
   task automatic latency_check(input int q, input int r, input string nm);
      logic [16:0] e;
      e = model(q, r);
      bus.IN_Q = 15'(q);
      bus.IN_R = 2'(r);
      bus.IN_VALID = 1'b1;
      bus.OUT_READY = 1'b1;
      @(negedge clk);
      check({nm, "_in_ready"}, 32'(bus.IN_READY), 32'd1);
      @(posedge clk);
      #1;
      bus.IN_VALID = 1'b0;
      check({nm, "_valid_early"}, 32'(bus.OUT_VALID), 32'd0);
      @(posedge clk);
      #1;
      check({nm, "_valid"}, 32'(bus.OUT_VALID), 32'd1);
      check({nm, "_x"}, 32'(bus.X_out), 32'(e[15:0]));
`ifdef MUL_16_3_RANGE_CHECK_EN
      check({nm, "_err"}, 32'(bus.ERR_out), 32'(e[16]));
`endif
      drain(nm);
   endtask

   initial begin
      int ov_cnt;
      int rdy_gap;
      int p0;
      int o0;
      logic last_acc;

      bus.IN_Q = '0;
      bus.IN_R = '0;
      bus.IN_VALID = 1'b0;
      bus.OUT_READY = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
      check("rst_x", 32'(bus.X_out), 32'd0);
      check("rst_in_ready", 32'(bus.IN_READY), 32'd1);
`ifdef MUL_16_3_RANGE_CHECK_EN
      check("rst_err", 32'(bus.ERR_out), 32'd0);
`endif
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      latency_check(21845, 0, "max");
      latency_check(5, 2, "q5r2");
      latency_check(21845, 1, "wrap");
      latency_check(0, 3, "r3");

      // Back-to-back stream: no input stalls, no output gaps
      ov_cnt = 0;
      rdy_gap = 0;
      o0 = n_pop;
      for (int i = 0; i < 102; i++) begin
         bus.IN_VALID = (i < 100);
         bus.IN_Q = 15'(i);
         bus.IN_R = 2'(i % 3);
         @(negedge clk);
         if (i < 100 && !bus.IN_READY) rdy_gap++;
         if (bus.OUT_VALID) ov_cnt++;
         @(posedge clk);
         #1;
      end
      check("stream_in_gaps", 32'(rdy_gap), 32'd0);
      check("stream_out_cnt", 32'(ov_cnt), 32'd100);
      check("stream_pops", 32'(n_pop - o0), 32'd100);
      drain("stream");

      // Backpressure: capacity two, third accepted on release
      p0 = n_push;
      bus.OUT_READY = 1'b0;
      bus.IN_VALID = 1'b1;
      bus.IN_R = 2'd0;
      bus.IN_Q = 15'd1;
      @(posedge clk);
      #1;
      bus.IN_Q = 15'd2;
      @(posedge clk);
      #1;
      bus.IN_Q = 15'd3;
      check("bp_full_ready", 32'(bus.IN_READY), 32'd0);
      check("bp_full_x", 32'(bus.X_out), 32'd3);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("bp_hold_ready", 32'(bus.IN_READY), 32'd0);
      end
      bus.OUT_READY = 1'b1;
      #1;
      check("bp_release_ready", 32'(bus.IN_READY), 32'd1);
      @(posedge clk);
      #1;
      bus.IN_VALID = 1'b0;
      check("bp_accepted", 32'(n_push - p0), 32'd3);
      drain("bp");

      // Full pipeline with OUT_READY toggling every cycle
      p0 = n_push;
      o0 = n_pop;
      for (int i = 0; i < 100; i++) begin
         bus.IN_VALID = 1'b1;
         bus.IN_Q = 15'($urandom);
         bus.IN_R = 2'($urandom_range(0, 2));
         bus.OUT_READY = i[0];
         @(posedge clk);
         #1;
      end
      drain("toggle");
      check("toggle_count", 32'(n_push - p0), 32'(n_pop - o0));

      // Random valid/ready with random operands, data held while not accepted
      last_acc = 1'b1;
      bus.IN_VALID = 1'b0;
      for (int i = 0; i < 400; i++) begin
         bus.OUT_READY = ($urandom_range(0, 3) != 0);
         if (!bus.IN_VALID || last_acc) begin
            bus.IN_VALID = ($urandom_range(0, 3) != 0);
            bus.IN_Q = ($urandom_range(0, 1) != 0) ? 15'($urandom_range(21840, 32767)) : 15'($urandom);
            bus.IN_R = 2'($urandom_range(0, 3));
         end
         @(negedge clk);
         last_acc = bus.IN_VALID && bus.IN_READY;
         @(posedge clk);
         #1;
      end
      drain("rand");

      // Reset with both stages full
      bus.OUT_READY = 1'b0;
      bus.IN_VALID = 1'b1;
      bus.IN_R = 2'd0;
      bus.IN_Q = 15'd100;
      @(posedge clk);
      #1;
      bus.IN_Q = 15'd200;
      @(posedge clk);
      #1;
      check("pre_rst_full", 32'(bus.IN_READY), 32'd0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.IN_VALID = 1'b0;
      check("mid_rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
      check("mid_rst_x", 32'(bus.X_out), 32'd0);
      check("mid_rst_in_ready", 32'(bus.IN_READY), 32'd1);
`ifdef MUL_16_3_RANGE_CHECK_EN
      check("mid_rst_err", 32'(bus.ERR_out), 32'd0);
`endif
      latency_check(7, 1, "post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual running required finished");
      $fatal(1);
   end

endmodule
